// File: rtl/ram_burst_ctrl.sv
// Burst read/write initiator for a single-port RAM (rw=0 write, rw=1 read).
// Latency: write beat -> RAM port 1 edge; read data -> rd_data RD_LAT+1 edges after its address.
// Backpressure: cmd_ready only in IDLE, wr_ready only in WRITE; rd_valid has no backpressure.
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_rw/   burst command: direction, start address,
//   cmd_addr/cmd_len              beats minus one
//   wr_data/wr_valid/wr_ready     write beat stream
//   rd_data/rd_valid              read beat stream (registered, must be taken)
//   busy                          controller not idle
//   ram_rw/ram_addr/ram_data_in   registered RAM port drive
//   ram_data_out                  RAM read data
module ram_burst_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] beats;
  // vld_pipe[k] set means the address issued k+1 edges ago was a read;
  // the tap at RD_LAT lines up with ram_data_out for that address.
  logic [RD_LAT:0]   vld_pipe;
  logic              cmd_fire;
  logic              wr_fire;
  logic              last_beat;

  // Gated by rst so no command is taken while reset is being applied.
  assign cmd_ready = (state == IDLE) && !rst;
  assign wr_ready  = (state == WRITE) && !rst;
  assign busy      = (state != IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_fire   = wr_valid && wr_ready;
  // beats counts completed beats, so it equals len on the final one.
  assign last_beat = (beats == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          state_nxt = cmd_rw ? READ : WRITE;
        end
      end
      WRITE: begin
        if (wr_fire && last_beat) begin
          state_nxt = IDLE;
        end
      end
      READ: begin
        if (last_beat) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (vld_pipe == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr    <= '0;
      len_q       <= '0;
      beats       <= '0;
      vld_pipe    <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      ram_rw      <= 1'b1;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      // RAM port idles in read so a stalled or idle cycle never writes.
      ram_rw   <= 1'b1;
      vld_pipe <= {vld_pipe[RD_LAT-1:0], (state == READ)};
      rd_valid <= vld_pipe[RD_LAT];
      if (vld_pipe[RD_LAT]) begin
        rd_data <= ram_data_out;
      end

      case (state)
        IDLE: begin
          if (cmd_fire) begin
            cur_addr <= cmd_addr;
            len_q    <= cmd_len;
            beats    <= '0;
          end
        end
        WRITE: begin
          if (wr_fire) begin
            ram_rw      <= 1'b0;
            ram_addr    <= cur_addr;
            ram_data_in <= wr_data;
            cur_addr    <= cur_addr + ONE;
            beats       <= beats + ONE;
          end
        end
        READ: begin
          ram_addr <= cur_addr;
          cur_addr <= cur_addr + ONE;
          beats    <= beats + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [2:0] cmd_addr;
  logic [2:0] cmd_len;
  logic [3:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       ram_rw;
  logic [2:0] ram_addr;
  logic [3:0] ram_data_in;
  logic [3:0] ram_data_out;

  int checks   = 0;
  int failures = 0;

  logic [6:0] wq[$];
  logic [3:0] rq[$];
  logic [6:0] we;
  logic [3:0] re;

  // Behavioural RAM with one edge of read latency.
  logic [3:0] mem[8];
  initial for (int i = 0; i < 8; i++) mem[i] = 4'h0;
  always @(posedge clk) begin
    if (ram_rw === 1'b0) mem[ram_addr] <= ram_data_in;
    else                 ram_data_out  <= mem[ram_addr];
  end

  ram_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every RAM write and every read beat must match the
  // next queued expectation.
  always @(negedge clk) begin
    if (ram_rw === 1'b0) begin
      if (wq.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected: got addr=%0d data=%0h, expected no write at %0t",
                 ram_addr, ram_data_in, $time);
      end else begin
        we = wq.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(we[6:4]));
        check("wr_data", 32'(ram_data_in), 32'(we[3:0]));
      end
    end
    if (rd_valid === 1'b1) begin
      if (rq.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected: got data=%0h, expected no beat at %0t", rd_data, $time);
      end else begin
        re = rq.pop_front();
        check("rd_data", 32'(rd_data), 32'(re));
      end
    end
  end

  task automatic send_cmd(input logic rw, input logic [2:0] addr, input logic [2:0] len);
    cmd_rw = rw; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    check("cmd_accept_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wr_beat(input logic [3:0] d, input logic [2:0] exp_addr);
    wq.push_back({exp_addr, d});
    wr_data = d; wr_valid = 1'b1;
    for (int i = 0; i < 50 && !wr_ready; i++) @(negedge clk);
    check("wr_ready_wait", 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && (busy || rq.size() != 0); i++) @(negedge clk);
    check("drain_wait", 32'({busy, rq.size() != 0}), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_rw", 32'(ram_rw), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write burst 0..3 at address 0
    send_cmd(1'b0, 3'd0, 3'd3);
    for (int i = 0; i < 4; i++) wr_beat(4'(i), 3'(i));
    @(posedge clk); @(negedge clk);
    check("wr_done_ram_rw", 32'(ram_rw), 32'd1);
    check("wr_done_cmd_ready", 32'(cmd_ready), 32'd1);

    // Read back with latency checks
    for (int i = 0; i < 4; i++) rq.push_back(4'(i));
    send_cmd(1'b1, 3'd0, 3'd3);
    @(posedge clk); @(negedge clk);
    check("rd_first_addr", 32'(ram_addr), 32'd0);
    check("rd_first_rw", 32'(ram_rw), 32'd1);
    @(negedge clk);
    check("rd_lat_not_early", 32'(rd_valid), 32'd0);
    @(negedge clk);
    check("rd_lat_on_time", 32'(rd_valid), 32'd1);
    wait_idle();

    // Wrapping burst 6,7,0,1
    send_cmd(1'b0, 3'd6, 3'd3);
    wr_beat(4'hA, 3'd6); wr_beat(4'hB, 3'd7); wr_beat(4'hC, 3'd0); wr_beat(4'hD, 3'd1);
    rq.push_back(4'hA); rq.push_back(4'hB); rq.push_back(4'hC); rq.push_back(4'hD);
    send_cmd(1'b1, 3'd6, 3'd3);
    wait_idle();

    // Write stall with a read command held during the burst
    send_cmd(1'b0, 3'd2, 3'd3);
    cmd_rw = 1'b1; cmd_addr = 3'd2; cmd_len = 3'd3; cmd_valid = 1'b1;
    wr_beat(4'h5, 3'd2); wr_beat(4'h6, 3'd3);
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("gap_ram_rw", 32'(ram_rw), 32'd1);
      check("gap_ram_addr", 32'(ram_addr), 32'd3);
      check("gap_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    wr_beat(4'h7, 3'd4); wr_beat(4'h8, 3'd5);
    rq.push_back(4'h5); rq.push_back(4'h6); rq.push_back(4'h7); rq.push_back(4'h8);
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    check("held_cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle();

    // Reset in the middle of an 8-beat read: only two beats expected
    rq.push_back(4'hC); rq.push_back(4'hD);
    send_cmd(1'b1, 3'd0, 3'd7);
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(negedge clk);
      if (rd_valid) n++;
    end
    check("mid_rd_beats_seen", 32'(n), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_ram_rw", 32'(ram_rw), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("mid_rst_no_beats", 32'(rd_valid), 32'd0);
    end

    // Single-beat read after reset
    rq.push_back(4'h8);
    send_cmd(1'b1, 3'd5, 3'd0);
    wait_idle();
    repeat (4) @(negedge clk);

    check("wq_empty", 32'(wq.size()), 32'd0);
    check("rq_empty", 32'(rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Initiator-side controller for the small single-port RAM (rw/addr/data_in/data_out port, rw=0 write, rw=1 read). It accepts burst read/write commands on a valid/ready interface and streams write beats in and read beats out. It generates the RAM port signals with auto-incrementing, wrapping addresses and realigns read data for the RAM's read latency. It sits between the AES datapath or its test sequencers and any RAM instance of this shape.

Parameters:
ADDR_W, 3, RAM address width; depth = 2**ADDR_W
DATA_W, 4, RAM data width
RD_LAT, 1, edges from ram_addr presented (with ram_rw=1) to valid ram_data_out; legal range 1..4

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_rw  input  1  0 = write burst, 1 = read burst (same polarity as RAM rw)
cmd_addr  input  ADDR_W  start address
cmd_len  input  ADDR_W  beats minus one (0 → 1 beat, 7 → 8 beats at default)
wr_data  input  DATA_W  write beat data
wr_valid  input  1  write beat offered
wr_ready  output  1  controller accepts write beat (high only in WRITE)
rd_data  output  DATA_W  read beat data (registered)
rd_valid  output  1  rd_data valid this cycle; no backpressure, sink must take it
busy  output  1  state != IDLE
ram_rw  output  1  to RAM rw (registered)
ram_addr  output  ADDR_W  to RAM addr (registered)
ram_data_in  output  DATA_W  to RAM data_in (registered)
ram_data_out  input  DATA_W  from RAM data_out

Behaviour:
- Reset values: cmd_ready=0 during rst, then 1 in the first cycle after; wr_ready=0, rd_valid=0, rd_data=0, busy=0, ram_rw=1 (read, never a spurious write), ram_addr=0, ram_data_in=0. State=IDLE, beat counter=0, read-valid pipeline cleared.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) latches addr and len. If cmd_rw=0 → WRITE, else → READ. ram_rw holds 1.
- WRITE: wr_ready=1. Each wr_valid & wr_ready edge registers ram_rw=0, ram_addr=cur_addr, ram_data_in=wr_data for exactly one cycle. Then cur_addr++ and beats++. A cycle with wr_valid=0 registers ram_rw=1 (write gap, no RAM write). After the (len+1)th beat handshake → IDLE; ram_rw returns to 1 on the next edge.
- READ: one address per cycle, no gaps. Each edge registers ram_rw=1, ram_addr=cur_addr and shifts a 1 into a RD_LAT+1 deep valid pipeline. After len+1 addresses → DRAIN.
- DRAIN: shifts 0s into the pipeline. Goes to IDLE when the pipeline is empty.
- Read return: when the pipeline tap is set, rd_data<=ram_data_out and rd_valid<=1. The first rd_valid occurs RD_LAT+1 edges after the first read address appears on ram_addr. Beats are consecutive, in address order, with exactly len+1 beats per command.
- Address arithmetic: cur_addr increments modulo 2**ADDR_W; a burst wraps 7→0 at default. len counts beats, not addresses; the maximum burst covers the whole RAM exactly once.
- Commands offered while busy are not accepted (cmd_ready=0) and are not lost; the offerer holds them.
- Reset mid-operation: the next state is IDLE. Outputs go to reset values on that edge, and in-flight read beats are discarded (rd_valid=0 from the reset edge). A write beat already registered onto the RAM port completes; no further writes occur.
- A command arriving the cycle after a burst finishes is accepted (back-to-back bursts permitted). A read after a write sees the written data, because the write lands one edge before the read address.

Test Plan:
- Reset: hold rst 2 cycles → ram_rw=1, rd_valid=0, wr_ready=0, busy=0; cmd_ready=1 the cycle after rst falls.
- Write burst cmd_rw=0, addr=0, len=3, wr_data 0,1,2,3 with wr_valid continuous → RAM port shows rw=0 with addr 0/1/2/3 and data 0/1/2/3 on 4 consecutive cycles, then rw=1 and cmd_ready=1.
- Read burst addr=0, len=3 after the above (RD_LAT=1) → rd_valid high 4 consecutive cycles with rd_data 0,1,2,3; the first beat arrives 2 edges after ram_addr=0; exactly 4 beats.
- Wrap: write addr=6, len=3, data A,B,C,D then read addr=6 len=3 → RAM addresses 6,7,0,1; read returns A,B,C,D.
- Write stall: drop wr_valid for 2 cycles mid-burst → ram_rw stays 1 during the gap, no address advance; the remaining beats land at the correct addresses; cmd_valid held during the burst gets cmd_ready=0 until IDLE.
- Reset during read burst (after 2 rd_valid beats, len=7) → rd_valid=0 from the reset edge, no further beats, ram_rw=1, IDLE; a subsequent read len=0 addr=5 returns one beat.
